// File: rtl/vga_pattern_gen.sv
// Purpose: VGA raster timing plus four test patterns (solid, 8 bars, checkerboard, bouncing box).
// Latency: hSync/vSync/bright/RGB are registered one pixel tick behind hCount/vCount; frameStart follows the (0,0) load by one clk.
// Backpressure: none, the raster free-runs; the bouncing box is compiled in only when PATTERN_BOUNCE_EN is defined.
module vga_pattern_gen #(
    parameter int CLK_DIV    = 4,
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CHECK_LOG2 = 5,
    parameter int BOX_SIZE   = 32
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [1:0]  mode,
    input  logic [11:0] fgColor,
    output logic        hSync,
    output logic        vSync,
    output logic        bright,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        frameStart,
    output logic [3:0]  vgaR,
    output logic [3:0]  vgaG,
    output logic [3:0]  vgaB
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST       = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] BAR_W        = 10'(H_VISIBLE / 8);

    // Elaboration-time guards on parameters that would break the raster or the box.
    if (CLK_DIV < 1) begin : g_bad_div
        $error("CLK_DIV must be at least 1");
    end
    if (BOX_SIZE < 1 || BOX_SIZE > H_VISIBLE || BOX_SIZE > V_VISIBLE) begin : g_bad_box
        $error("BOX_SIZE must fit inside the visible area");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic [1:0]       mode_q, mode_d;
    logic [11:0]      color_q, color_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             bright_q, bright_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             frame_start_q, frame_start_d;

    logic             pix_en;
    logic             frame_tick;
    logic             visible;
    logic [9:0]       bar_num;
    logic [2:0]       bar_idx;
    logic             in_box;
    logic [11:0]      pattern;

`ifdef PATTERN_BOUNCE_EN
    localparam logic [9:0] BOX_C = 10'(BOX_SIZE);

    logic [9:0] bx_q, bx_d, by_q, by_d;
    logic       dx_q, dx_d, dy_q, dy_d;   // 1 = moving towards larger coordinates
`endif

    // Pixel divider, raster counters, frame-start pulse and shadow capture of mode/colour.
    always_comb begin
        pix_en        = (div_q == DIV_LAST);
        frame_tick    = pix_en && (h_q == 10'd0) && (v_q == 10'd0);
        div_d         = pix_en ? '0 : div_q + 1'b1;
        h_d           = h_q;
        v_d           = v_q;
        frame_start_d = pix_en && (h_q == H_LAST) && (v_q == V_LAST);
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = 10'd0;
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        // The frame's first pixel already uses the freshly captured values.
        mode_d  = frame_tick ? mode    : mode_q;
        color_d = frame_tick ? fgColor : color_q;
    end

`ifdef PATTERN_BOUNCE_EN
    // Box position steps once per frame and reverses on touching an edge; decode sees the new position.
    always_comb begin
        bx_d = bx_q;
        by_d = by_q;
        dx_d = dx_q;
        dy_d = dy_q;
        if (frame_tick) begin
            if (dx_q) begin
                if (bx_q + BOX_C == H_VIS) begin
                    dx_d = 1'b0;
                    bx_d = bx_q - 10'd1;
                end else begin
                    bx_d = bx_q + 10'd1;
                end
            end else if (bx_q == 10'd0) begin
                dx_d = 1'b1;
                bx_d = bx_q + 10'd1;
            end else begin
                bx_d = bx_q - 10'd1;
            end

            if (dy_q) begin
                if (by_q + BOX_C == V_VIS) begin
                    dy_d = 1'b0;
                    by_d = by_q - 10'd1;
                end else begin
                    by_d = by_q + 10'd1;
                end
            end else if (by_q == 10'd0) begin
                dy_d = 1'b1;
                by_d = by_q + 10'd1;
            end else begin
                by_d = by_q - 10'd1;
            end
        end
        in_box = (h_q >= bx_d) && (h_q < bx_d + BOX_C) &&
                 (v_q >= by_d) && (v_q < by_d + BOX_C);
    end
`else
    // No box state in this build: mode 3 shows black.
    always_comb begin
        in_box = 1'b0;
    end
`endif

    // Decode the current counts into syncs, blanking and pattern colour; capture them on the pixel tick.
    always_comb begin
        visible = (h_q < H_VIS) && (v_q < V_VIS);
        bar_num = h_q / BAR_W;
        bar_idx = bar_num[2:0];
        case (mode_d)
            2'd0:    pattern = color_d;
            2'd1:    pattern = {{4{~bar_idx[1]}}, {4{~bar_idx[2]}}, {4{~bar_idx[0]}}};
            2'd2:    pattern = (h_q[CHECK_LOG2] ^ v_q[CHECK_LOG2]) ? 12'h000 : color_d;
            default: pattern = in_box ? color_d : 12'h000;
        endcase
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        bright_d = bright_q;
        rgb_d    = rgb_q;
        if (pix_en) begin
            hsync_d  = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
            vsync_d  = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
            bright_d = visible;
            rgb_d    = visible ? pattern : 12'h000;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            div_q         <= '0;
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            mode_q        <= 2'd0;
            color_q       <= 12'h000;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            bright_q      <= 1'b0;
            rgb_q         <= 12'h000;
            frame_start_q <= 1'b0;
`ifdef PATTERN_BOUNCE_EN
            bx_q          <= 10'd0;
            by_q          <= 10'd0;
            dx_q          <= 1'b1;
            dy_q          <= 1'b1;
`endif
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            mode_q        <= mode_d;
            color_q       <= color_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            bright_q      <= bright_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
`ifdef PATTERN_BOUNCE_EN
            bx_q          <= bx_d;
            by_q          <= by_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
`endif
        end
    end

    assign hCount             = h_q;
    assign vCount             = v_q;
    assign hSync              = hsync_q;
    assign vSync              = vsync_q;
    assign bright             = bright_q;
    assign frameStart         = frame_start_q;
    assign {vgaR, vgaG, vgaB} = rgb_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Purpose: directed checks of raster timing, syncs, patterns, frame-start pulse and reset on a shrunken raster.
// Latency: displayed pixel (h,v) is sampled at the negedge where the counts have advanced one tick past it.
// Backpressure: not applicable; every wait on the DUT is bounded by a cycle budget.
module tb_vga_pattern_gen;

    localparam int CLK_DIV = 2;
    localparam int HV = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VV = 8,  VFP = 1, VS = 2, VBP = 1;
    localparam int H_TOT = HV + HFP + HS + HBP;     // 24
    localparam int V_TOT = VV + VFP + VS + VBP;     // 12
    localparam int FRAME_CLKS = H_TOT * V_TOT * CLK_DIV;   // 576
    localparam int WAIT_MAX = 1500;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [11:0] fgColor = 12'hABC;
    logic        hSync, vSync, bright, frameStart;
    logic [9:0]  hCount, vCount;
    logic [3:0]  vgaR, vgaG, vgaB;

    int errors = 0;
    int checks = 0;
    int frame  = 0;

    int clk_cnt = 0;
    int last_fs = 0;
    int last_gap = 0;
    int fs_cnt = 0;

    vga_pattern_gen #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .CHECK_LOG2(2), .BOX_SIZE(4)
    ) dut (
        .clk(clk), .Reset(Reset), .mode(mode), .fgColor(fgColor),
        .hSync(hSync), .vSync(vSync), .bright(bright),
        .hCount(hCount), .vCount(vCount), .frameStart(frameStart),
        .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB)
    );

    always #5 clk = ~clk;

    // Interval between frameStart pulses and how many have been seen.
    always @(negedge clk) begin
        clk_cnt <= clk_cnt + 1;
        if (frameStart === 1'b1) begin
            last_gap <= clk_cnt - last_fs;
            last_fs  <= clk_cnt;
            fs_cnt   <= fs_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_counts(input int h, input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(hCount == 10'(h) && vCount == 10'(v)) && n < WAIT_MAX);
        if (!(hCount == 10'(h) && vCount == 10'(v))) begin
            chk("wait_h", 32'(hCount), 32'(h));
            chk("wait_v", 32'(vCount), 32'(v));
        end
    endtask

    // Wait until pixel (h,v) is on the outputs, then check colour and blanking.
    task automatic px(input string tag, input int h, input int v,
                      input logic [11:0] exp_rgb, input logic exp_bright);
        int nh = h + 1;
        int nv = v;
        if (nh == H_TOT) begin
            nh = 0;
            nv = (v + 1 == V_TOT) ? 0 : v + 1;
        end
        wait_counts(nh, nv);
        chk({tag, "_rgb"}, 32'({vgaR, vgaG, vgaB}), 32'(exp_rgb));
        chk({tag, "_bright"}, 32'(bright), 32'(exp_bright));
    endtask

    task automatic next_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frameStart !== 1'b1 && n < WAIT_MAX);
        if (frameStart !== 1'b1) chk("frameStart_seen", 32'(frameStart), 32'd1);
        frame++;
    endtask

    task automatic first_tick(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (hCount == 10'd0 && n < 20);
        chk(tag, n, CLK_DIV);
    endtask

    task automatic reset_state(input string tag);
        chk({tag, "_h"}, 32'(hCount), 32'd0);
        chk({tag, "_v"}, 32'(vCount), 32'd0);
        chk({tag, "_hs"}, 32'(hSync), 32'd1);
        chk({tag, "_vs"}, 32'(vSync), 32'd1);
        chk({tag, "_bright"}, 32'(bright), 32'd0);
        chk({tag, "_rgb"}, 32'({vgaR, vgaG, vgaB}), 32'h000);
        chk({tag, "_fs"}, 32'(frameStart), 32'd0);
    endtask

    initial begin
        // Reset values, then first pixel tick CLK_DIV clks after release.
        repeat (3) @(negedge clk);
        reset_state("rst");
        Reset = 1'b0;
        first_tick("first_tick");
        frame = 1;

        // Frame 1: solid colour, blanking and syncs.
        px("f1_p00", 0, 0, 12'hABC, 1'b1);
        chk("f1_hs_vis", 32'(hSync), 32'd1);
        px("f1_p16", 16, 0, 12'h000, 1'b0);
        chk("f1_hs16", 32'(hSync), 32'd1);
        px("f1_p17", 17, 0, 12'h000, 1'b0);
        chk("f1_hs17", 32'(hSync), 32'd1);
        px("f1_p18", 18, 0, 12'h000, 1'b0);
        chk("f1_hs18", 32'(hSync), 32'd0);
        px("f1_p20", 20, 0, 12'h000, 1'b0);
        chk("f1_hs20", 32'(hSync), 32'd0);
        px("f1_p21", 21, 0, 12'h000, 1'b0);
        chk("f1_hs21", 32'(hSync), 32'd1);
        px("f1_p35", 3, 5, 12'hABC, 1'b1);
        mode = 2'd1;                        // mid-frame change: must wait for next frame
        px("f1_p157", 15, 7, 12'hABC, 1'b1);
        px("f1_p08", 0, 8, 12'h000, 1'b0);
        chk("f1_vs8", 32'(vSync), 32'd1);
        px("f1_p09", 0, 9, 12'h000, 1'b0);
        chk("f1_vs9", 32'(vSync), 32'd0);
        px("f1_p510", 5, 10, 12'h000, 1'b0);
        chk("f1_vs10", 32'(vSync), 32'd0);
        px("f1_p011", 0, 11, 12'h000, 1'b0);
        chk("f1_vs11", 32'(vSync), 32'd1);

        // Frame 2: colour bars, two pixels per bar.
        next_frame();
        @(negedge clk);
        chk("fs_width", 32'(frameStart), 32'd0);
        px("f2_bar0", 0, 0, 12'hFFF, 1'b1);
        chk("fs_count1", fs_cnt, 1);
        px("f2_bar1", 2, 1, 12'hFF0, 1'b1);
        px("f2_bar2", 4, 1, 12'h0FF, 1'b1);
        px("f2_bar3", 6, 1, 12'h0F0, 1'b1);
        px("f2_bar5", 10, 2, 12'hF00, 1'b1);
        px("f2_bar7", 15, 3, 12'h000, 1'b1);
        mode = 2'd2;
        fgColor = 12'h0F0;

        // Frame 3: checkerboard with 4-pixel cells.
        next_frame();
        px("f3_c00", 0, 0, 12'h0F0, 1'b1);
        chk("fs_count2", fs_cnt, 2);
        chk("frame_len", last_gap, FRAME_CLKS);
        px("f3_c40", 4, 0, 12'h000, 1'b1);
        px("f3_c04", 0, 4, 12'h000, 1'b1);
        px("f3_c44", 4, 4, 12'h0F0, 1'b1);
        mode = 2'd3;
        fgColor = 12'hF0F;

        // Frame 4 onwards: bouncing box.
        next_frame();
`ifdef PATTERN_BOUNCE_EN
        px("f4_out_l", 3, 4, 12'h000, 1'b1);
        px("f4_in_tl", 4, 4, 12'hF0F, 1'b1);
        px("f4_in_br", 7, 7, 12'hF0F, 1'b1);
        px("f4_out_r", 8, 7, 12'h000, 1'b1);
        next_frame();
        px("f5_out_l", 4, 3, 12'h000, 1'b1);
        px("f5_in_tl", 5, 3, 12'hF0F, 1'b1);
        px("f5_in_br", 8, 6, 12'hF0F, 1'b1);
        px("f5_out_b", 5, 7, 12'h000, 1'b1);
        while (frame < 12) next_frame();
        px("f12_out_l", 11, 4, 12'h000, 1'b1);
        px("f12_in_tl", 12, 4, 12'hF0F, 1'b1);
        px("f12_in_br", 15, 7, 12'hF0F, 1'b1);
        next_frame();
        px("f13_in_tl", 11, 3, 12'hF0F, 1'b1);
        px("f13_out_r", 15, 3, 12'h000, 1'b1);
        px("f13_out_b", 11, 7, 12'h000, 1'b1);
        next_frame();
        px("f14_in_tl", 10, 2, 12'hF0F, 1'b1);
        px("f14_out_r", 14, 2, 12'h000, 1'b1);
`else
        px("f4_blk_a", 4, 4, 12'h000, 1'b1);
        px("f4_blk_b", 7, 7, 12'h000, 1'b1);
`endif

        // Reset in the middle of the vertical sync.
        wait_counts(3, 9);
        chk("pre_rst_vs", 32'(vSync), 32'd0);
        Reset = 1'b1;
        @(negedge clk);
        reset_state("midrst");
        Reset = 1'b0;
        first_tick("first_tick2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA timing and test-pattern generator replacing the fixed white-screen path on the Nexys4 top level. It owns its own horizontal/vertical counters with a configurable pixel-clock divider and drives sync, counts and 12-bit colour directly to the VGA pins. Four selectable patterns are provided for bring-up and monitor checks: solid colour, 8 colour bars, checkerboard and a bouncing box.

## Interface
- CLK_DIV, 4: system clocks per pixel (4 gives 25 MHz from 100 MHz); must be ≥1.
- H_VISIBLE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixels.
- V_VISIBLE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines.
- CHECK_LOG2, 5: checkerboard cell edge is 2^CHECK_LOG2 pixels.
- BOX_SIZE, 32: bouncing box edge in pixels.
- clk  in  1  system clock; one clock domain.
- Reset  in  1  synchronous, active-high reset.
- mode  in  2  pattern select: 0 solid, 1 bars, 2 checker, 3 box.
- fgColor  in  12  {R,G,B} 4 bits each; foreground colour.
- hSync, vSync  out  1  active-low syncs.
- bright  out  1  high while the displayed pixel is visible.
- hCount, vCount  out  10  current counter values.
- frameStart  out  1  one-clk pulse at the pixel tick where counts wrap to (0,0).
- vgaR, vgaG, vgaB  out  4  colour outputs.

## Operation
- Divider counts 0..CLK_DIV-1; pixel tick (pix_en) asserted on the clk where it equals CLK_DIV-1.
- On pix_en: hCount increments, wraps at H_TOTAL-1 = H_VISIBLE+H_FP+H_SYNC+H_BP-1 (799); on wrap vCount increments, wraps at V_TOTAL-1 (524).
- Decode from current counts: visible = hCount<H_VISIBLE && vCount<V_VISIBLE; hSync low for hCount in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC); vSync same on vCount.
- mode and fgColor sampled into shadow registers only on the pix_en where counts are (0,0); mid-frame changes take effect next frame.
- Pattern (visible only, else 12'h000):
  - 0: fgColor.
  - 1: bar b = hCount/(H_VISIBLE/8), 0..7; R=~b[1], G=~b[2], B=~b[0], each 4'hF or 4'h0 (white, yellow, cyan, green, magenta, red, blue, black).
  - 2: fgColor when hCount[CHECK_LOG2]^vCount[CHECK_LOG2]==0, else black.
  - 3: fgColor inside box [bx,bx+BOX_SIZE)×[by,by+BOX_SIZE), else black.
- Box state bx, by (10 bit), dx, dy (direction). Updated once per frame at (0,0) tick: step ±1 each axis; if moving + and bx+BOX_SIZE == H_VISIBLE, flip dx and step −1 instead; if moving − and bx==0, flip and step +1. Same for y with V_VISIBLE. Box updates regardless of mode.

## Timing
- Reset: divider 0, hCount=vCount=0, hSync=vSync=1, bright=0, RGB=0, frameStart=0, bx=by=0, dx=dy=+, shadow mode=0, shadow colour=12'h000.
- hSync, vSync, bright, vgaR/G/B are registered on pix_en from the decode of the current counts: they lag hCount/vCount by exactly one pixel tick and are mutually aligned.
- frameStart is high for one clk, the clk after the pix_en that loads (0,0).
- Reset asserted mid-frame restores all reset values on the next clk edge; first pix_en after release occurs CLK_DIV clks later.
- CLK_DIV=1: pix_en constantly high.

## Configuration
- PATTERN_BOUNCE_EN: defined → box registers and mode 3 logic compiled in as above. Undefined → no box state; mode 3 outputs black in the visible area; all other modes unchanged.

## Test plan
- Reset, default params: first pix_en at clk 4; hCount wraps 799→0 after 800 ticks; vCount 524→0; frame = 420000 ticks, frameStart once per frame.
- Sync check: hSync low exactly for displayed hCount 656..751 (96 ticks), vSync low for lines 490..491; bright low outside 640×480.
- mode=1: displayed pixels at hCount 0, 80, 400, 639 give 12'hFFF, 12'hFF0, 12'hF00, 12'h000.
- mode=2, fgColor=12'h0F0: pixel (0,0) green, (32,0) black, (32,32) green.
- mode changed 0→1 at vCount=100: remainder of frame stays solid; bars start at next frame.
- PATTERN_BOUNCE_EN defined, mode=3: after frame 608 box at bx=608 and dx flips; next frame bx=607; by reverses at 448. Without macro: all pixels 12'h000.
